// File: rtl/sysid_regbank_if.sv
// rtl/sysid_regbank_if.sv - Avalon-MM style bus bundle for sysid_regbank
// Purpose: groups the word-addressed slave bus signals of the register bank.
// Signals:
//   address[2:0]     word address (master -> slave)
//   read, write      transfer strobes, one transfer per cycle (master -> slave)
//   byteenable[3:0]  write byte lanes (master -> slave)
//   writedata[31:0]  write data (master -> slave)
//   readdata[31:0]   registered read data (slave -> master)
//   readdatavalid    one-cycle pulse per accepted read (slave -> master)
interface sysid_regbank_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regbank.sv
// rtl/sysid_regbank.sv - system-identification register bank on a word-addressed slave bus
// Purpose: returns build ID, timestamp, version and capability words, provides
//   up to two byte-writable scratch words and an optional 64-bit uptime counter.
//   Read latency is fixed at one cycle; there is no wait state.
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-high reset
//   bus    sysid_regbank_if.slave (address, read, write, byteenable,
//          writedata in; readdata, readdatavalid out)
// Configuration macro: SYSID_UPTIME_EN - when defined, adds the uptime
//   counter at words 4/5 and sets CAPS[8]; when undefined, words 4/5 read 0.
module sysid_regbank #(
  parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
  parameter logic [31:0] VERSION     = 32'h0001_0000,
  parameter int          NUM_SCRATCH = 2,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input logic            clock,
  input logic            reset,
  sysid_regbank_if.slave bus
);

  // Out-of-range scratch counts are clamped so CAPS always matches the hardware.
  localparam int NS = (NUM_SCRATCH > 2) ? 2 : ((NUM_SCRATCH < 0) ? 0 : NUM_SCRATCH);
  localparam logic [1:0] NS_FIELD = 2'(NS);

`ifdef SYSID_UPTIME_EN
  localparam logic UPTIME_PRESENT = 1'b1;
`else
  localparam logic UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAPS = {23'd0, UPTIME_PRESENT, 6'd0, NS_FIELD};

  logic [31:0] scratch [2];
  logic [31:0] rd_word;

  // Scratch words: per-lane update; words beyond NS never change and read as 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        scratch[i] <= SCRATCH_RST;
      end
    end else if (bus.write) begin
      for (int i = 0; i < 2; i++) begin
        if ((i < NS) && (bus.address == 3'(6 + i))) begin
          for (int k = 0; k < 4; k++) begin
            if (bus.byteenable[k]) begin
              scratch[i][8*k +: 8] <= bus.writedata[8*k +: 8];
            end
          end
        end
      end
    end
  end

`ifdef SYSID_UPTIME_EN
  logic [63:0] uptime;
  logic [31:0] snapshot;

  // A write to word 4 clears the counter and takes priority over counting.
  // Reading word 4 captures the upper half so a following read of word 5
  // returns a value consistent with the lower half already read.
  always_ff @(posedge clock) begin
    if (reset) begin
      uptime   <= 64'd0;
      snapshot <= 32'd0;
    end else begin
      if (bus.write && (bus.address == 3'd4)) begin
        uptime <= 64'd0;
      end else begin
        uptime <= uptime + 64'd1;
      end
      if (bus.read && (bus.address == 3'd4)) begin
        snapshot <= uptime[63:32];
      end
    end
  end
`endif

  // Read mux sees pre-update register values, so a same-cycle write is not
  // reflected in the data returned for that read.
  always_comb begin
    rd_word = 32'd0;
    case (bus.address)
      3'd0: rd_word = ID_VALUE;
      3'd1: rd_word = TIMESTAMP;
      3'd2: rd_word = VERSION;
      3'd3: rd_word = CAPS;
`ifdef SYSID_UPTIME_EN
      3'd4: rd_word = uptime[31:0];
      3'd5: rd_word = snapshot;
`endif
      3'd6: rd_word = (NS > 0) ? scratch[0] : 32'd0;
      3'd7: rd_word = (NS > 1) ? scratch[1] : 32'd0;
      default: rd_word = 32'd0;
    endcase
  end

  // Reset has priority, so a read sampled together with reset never completes.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.readdata      <= 32'd0;
      bus.readdatavalid <= 1'b0;
    end else begin
      bus.readdatavalid <= bus.read;
      if (bus.read) begin
        bus.readdata <= rd_word;
      end
    end
  end

endmodule

// File: tb/tb_sysid_regbank.sv
// tb/tb_sysid_regbank.sv - self-checking bench for sysid_regbank
// Purpose: table-driven register accesses with a read-data scoreboard, plus
//   hand-written sequences for reset, hold, uptime and scratch-count variants.
// Ports: none (top-level bench). Honours SYSID_UPTIME_EN like the design.
module tb_sysid_regbank;

  localparam logic [31:0] ID_M  = 32'hA5A5_0001;
  localparam logic [31:0] TS_M  = 32'h6512_3456;
  localparam logic [31:0] VER_M = 32'h0002_0003;

`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] CAPS_2 = 32'h0000_0102;
  localparam logic [31:0] CAPS_1 = 32'h0000_0101;
`else
  localparam logic [31:0] CAPS_2 = 32'h0000_0002;
  localparam logic [31:0] CAPS_1 = 32'h0000_0001;
`endif

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    bit          lt;
    string       name;
  } sb_t;

  logic clock;
  logic reset;
  int   total;
  int   bad;
  sb_t  sbq[$];
  sb_t  sb_e;
  bit   mon_exp_v;
  vec_t tbl[$];

  sysid_regbank_if bus0 ();
  sysid_regbank_if bus1 ();
  sysid_regbank_if bus5 ();

  assign bus1.address    = bus0.address;
  assign bus1.read       = bus0.read;
  assign bus1.write      = bus0.write;
  assign bus1.byteenable = bus0.byteenable;
  assign bus1.writedata  = bus0.writedata;
  assign bus5.address    = bus0.address;
  assign bus5.read       = bus0.read;
  assign bus5.write      = bus0.write;
  assign bus5.byteenable = bus0.byteenable;
  assign bus5.writedata  = bus0.writedata;

  sysid_regbank #(
    .ID_VALUE(ID_M), .TIMESTAMP(TS_M), .VERSION(VER_M),
    .NUM_SCRATCH(2), .SCRATCH_RST(32'h0000_0000)
  ) dut (.clock(clock), .reset(reset), .bus(bus0));

  sysid_regbank #(
    .NUM_SCRATCH(1), .SCRATCH_RST(32'hC3C3_C3C3)
  ) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  sysid_regbank #(
    .NUM_SCRATCH(5)
  ) dut5 (.clock(clock), .reset(reset), .bus(bus5));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [2:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] exp, input bit lt, input string name);
    @(negedge clock);
    bus0.read       = rd;
    bus0.write      = wr;
    bus0.address    = a;
    bus0.byteenable = be;
    bus0.writedata  = wd;
    if (rd) sbq.push_back('{exp, lt, name});
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 4'd0, 32'd0, 32'd0, 1'b0, "");
  endtask

  function automatic vec_t mk(input bit rd, input bit wr, input logic [2:0] a, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] exp, input string name);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.be = be; v.wdata = wd; v.exp = exp; v.name = name;
    return v;
  endfunction

  // Scoreboard monitor: readdatavalid must follow each accepted read by one
  // cycle, and each returned word is matched against the oldest expectation.
  always @(posedge clock) begin
    mon_exp_v = bus0.read && !reset;
    #1;
    chk("rdv_timing", 32'(bus0.readdatavalid), 32'(mon_exp_v));
    if (bus0.readdatavalid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %08h expected no read data", bus0.readdata);
      end else begin
        sb_e = sbq.pop_front();
        if (sb_e.lt) begin
          total++;
          if (!(bus0.readdata < sb_e.exp)) begin
            bad++;
            $display("FAIL %s: got %08h expected below %08h", sb_e.name, bus0.readdata, sb_e.exp);
          end
        end else begin
          chk(sb_e.name, bus0.readdata, sb_e.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    clock = 1'b0;
    reset = 1'b1;
    bus0.read = 1'b0; bus0.write = 1'b0; bus0.address = 3'd0;
    bus0.byteenable = 4'd0; bus0.writedata = 32'd0;

    repeat (3) @(negedge clock);
    chk("rst_readdata", bus0.readdata, 32'd0);
    chk("rst_rdv", 32'(bus0.readdatavalid), 32'd0);
    chk("rst_readdata_n1", bus1.readdata, 32'd0);
    reset = 1'b0;

    tbl.push_back(mk(1, 0, 3'd0, 4'h0, 32'h0,         ID_M,          "rd_id"));
    tbl.push_back(mk(1, 0, 3'd1, 4'h0, 32'h0,         TS_M,          "rd_ts"));
    tbl.push_back(mk(1, 0, 3'd2, 4'h0, 32'h0,         VER_M,         "rd_ver"));
    tbl.push_back(mk(1, 0, 3'd3, 4'h0, 32'h0,         CAPS_2,        "rd_caps"));
    tbl.push_back(mk(0, 1, 3'd6, 4'h5, 32'hDEAD_BEEF, 32'h0,         "wr_s0_be5"));
    tbl.push_back(mk(1, 0, 3'd6, 4'h0, 32'h0,         32'h00AD_00EF, "rd_s0_be5"));
    tbl.push_back(mk(1, 1, 3'd7, 4'hF, 32'h1234_5678, 32'h0000_0000, "rw_s1_prewrite"));
    tbl.push_back(mk(1, 0, 3'd7, 4'h0, 32'h0,         32'h1234_5678, "rd_s1_after"));
    tbl.push_back(mk(0, 1, 3'd6, 4'h0, 32'hFFFF_FFFF, 32'h0,         "wr_s0_be0"));
    tbl.push_back(mk(1, 0, 3'd6, 4'h0, 32'h0,         32'h00AD_00EF, "rd_s0_be0"));
    tbl.push_back(mk(0, 1, 3'd6, 4'hA, 32'hCAFE_F00D, 32'h0,         "wr_s0_beA"));
    tbl.push_back(mk(1, 0, 3'd6, 4'h0, 32'h0,         32'hCAAD_F0EF, "rd_s0_beA"));
    tbl.push_back(mk(0, 1, 3'd0, 4'hF, 32'h1234_5678, 32'h0,         "wr_id_ro"));
    tbl.push_back(mk(1, 0, 3'd0, 4'h0, 32'h0,         ID_M,          "rd_id_ro"));
    tbl.push_back(mk(1, 1, 3'd2, 4'hF, 32'h0BAD_0BAD, VER_M,         "rw_ver_ro"));
    tbl.push_back(mk(1, 0, 3'd2, 4'h0, 32'h0,         VER_M,         "rd_ver_ro"));
`ifndef SYSID_UPTIME_EN
    tbl.push_back(mk(1, 0, 3'd4, 4'h0, 32'h0,         32'h0,         "rd_up_lo_off"));
    tbl.push_back(mk(0, 1, 3'd4, 4'hF, 32'hFFFF_FFFF, 32'h0,         "wr_up_lo_off"));
    tbl.push_back(mk(1, 0, 3'd5, 4'h0, 32'h0,         32'h0,         "rd_up_hi_off"));
    tbl.push_back(mk(1, 0, 3'd4, 4'h0, 32'h0,         32'h0,         "rd_up_lo_off2"));
`endif

    foreach (tbl[i]) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].exp, 1'b0, tbl[i].name);
    end

    // readdata must hold its last value across idle cycles
    drive(1, 0, 3'd1, 4'h0, 32'h0, TS_M, 1'b0, "rd_ts_hold");
    repeat (3) idle();
    chk("hold_readdata", bus0.readdata, TS_M);

`ifdef SYSID_UPTIME_EN
    // LO read latches HI; live HI moves to 1 but word 5 returns the snapshot
    @(negedge clock);
    force dut.uptime = 64'h0000_0000_FFFF_FFFF;
    bus0.read = 1'b1; bus0.write = 1'b0; bus0.address = 3'd4;
    sbq.push_back('{32'hFFFF_FFFF, 1'b0, "up_lo"});
    #1 release dut.uptime;
    idle();
    idle();
    drive(1, 0, 3'd5, 4'h0, 32'h0, 32'h0, 1'b0, "up_hi_snapshot");
    // Same-cycle read+write of word 4 returns the pre-clear value
    @(negedge clock);
    force dut.uptime = 64'h0000_0001_2345_6789;
    bus0.read = 1'b1; bus0.write = 1'b1; bus0.address = 3'd4;
    bus0.byteenable = 4'hF; bus0.writedata = 32'd0;
    sbq.push_back('{32'h2345_6789, 1'b0, "up_lo_preclear"});
    #1 release dut.uptime;
    drive(1, 0, 3'd5, 4'h0, 32'h0, 32'h0000_0001, 1'b0, "up_hi_preclear");
    drive(1, 0, 3'd4, 4'h0, 32'h0, 32'd4, 1'b1, "up_lo_cleared");
    idle();
`endif

    // Reset sampled together with a read: no readdatavalid, readdata cleared
    drive(0, 1, 3'd6, 4'hF, 32'h5A5A_5A5A, 32'h0, 1'b0, "wr_s0_full");
    drive(1, 0, 3'd6, 4'h0, 32'h0, 32'h5A5A_5A5A, 1'b0, "rd_s0_full");
    @(negedge clock);
    reset = 1'b1;
    bus0.read = 1'b1; bus0.write = 1'b0; bus0.address = 3'd6;
    @(negedge clock);
    chk("midrd_rst_readdata", bus0.readdata, 32'd0);
    reset = 1'b0;
    bus0.read = 1'b0;

    // Scratch back at reset values; NUM_SCRATCH=1 and clamped NUM_SCRATCH=5 variants
    drive(1, 0, 3'd6, 4'h0, 32'h0, 32'h0, 1'b0, "rst_s0");
    idle();
    chk("n1_s0_rst", bus1.readdata, 32'hC3C3_C3C3);
    chk("n5_s0_rst", bus5.readdata, 32'h0);
    drive(1, 0, 3'd7, 4'h0, 32'h0, 32'h1234_5678 & 32'h0, 1'b0, "rst_s1");
    idle();
    chk("n1_s1_unimpl", bus1.readdata, 32'h0);
    drive(0, 1, 3'd7, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b0, "wr_s1_ones");
    drive(1, 0, 3'd7, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0, "rd_s1_ones");
    idle();
    chk("n1_s1_ignored", bus1.readdata, 32'h0);
    chk("n5_s1_clamped", bus5.readdata, 32'hFFFF_FFFF);
    drive(1, 0, 3'd3, 4'h0, 32'h0, CAPS_2, 1'b0, "rd_caps_again");
    idle();
    chk("n1_caps", bus1.readdata, CAPS_1);
    chk("n5_caps_clamped", bus5.readdata, CAPS_2);

    repeat (3) idle();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
